// File: rtl/hdlverifier_capture_ctrl_if.sv
// Host/comparator side bus of the capture controller: arm/trigger controls in,
// capture RAM write port and trigger-position status out.
interface hdlverifier_capture_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int NTRIG  = 4
);
  logic              clk_enable;
  logic              arm;
  logic              abort;
  logic              force_trig;
  logic [NTRIG-1:0]  trig_in;
  logic [NTRIG-1:0]  trig_mask;
  logic              trig_and;
  logic [ADDR_W-1:0] pre_count;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              waiting;
  logic              done;

  modport master (
    output clk_enable, arm, abort, force_trig, trig_in, trig_mask, trig_and, pre_count,
    input  wr_en, wr_addr, trig_addr, start_addr, busy, waiting, done
  );

  modport slave (
    input  clk_enable, arm, abort, force_trig, trig_in, trig_mask, trig_and, pre_count,
    output wr_en, wr_addr, trig_addr, start_addr, busy, waiting, done
  );
endinterface

// File: rtl/hdlverifier_capture_ctrl.sv
// Sequences one capture window into a circular RAM: pre-trigger fill, trigger
// wait with mask/AND/OR combining, post-trigger fill, then reports positions.
module hdlverifier_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int NTRIG  = 4
) (
  input  logic clk,
  input  logic reset,
  hdlverifier_capture_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PREFILL   = 3'd1;
  localparam logic [2:0] WAIT_TRIG = 3'd2;
  localparam logic [2:0] POST      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] trigAddr_q, trigAddr_d;
  logic [ADDR_W-1:0] startAddr_q, startAddr_d;
  logic [ADDR_W-1:0] preCnt_q, preCnt_d;
  logic [ADDR_W-1:0] sampleCnt_q, sampleCnt_d;
  logic [ADDR_W-1:0] postCnt_q, postCnt_d;
  logic [NTRIG-1:0]  mask_q, mask_d;
  logic              andMode_q, andMode_d;

  logic              busy;
  logic              combTrig;
  logic              trigHit;
  logic [ADDR_W-1:0] postLoad;

  always_comb begin
    combTrig = 1'b0;
    if (mask_q != '0) begin
      if (andMode_q) combTrig = &(bus.trig_in | ~mask_q);
      else           combTrig = |(bus.trig_in & mask_q);
    end
  end

  assign trigHit  = (state_q == WAIT_TRIG) && (combTrig || bus.force_trig);
  assign postLoad = {ADDR_W{1'b1}} - preCnt_q;

  always_comb begin
    state_d     = state_q;
    wrAddr_d    = wrAddr_q;
    trigAddr_d  = trigAddr_q;
    startAddr_d = startAddr_q;
    preCnt_d    = preCnt_q;
    sampleCnt_d = sampleCnt_q;
    postCnt_d   = postCnt_q;
    mask_d      = mask_q;
    andMode_d   = andMode_q;

    if (bus.clk_enable) begin
      if (bus.abort) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            // An ADDR_W-bit pre_count can never exceed DEPTH-1, so it is already clamped.
            if (bus.arm) begin
              mask_d      = bus.trig_mask;
              andMode_d   = bus.trig_and;
              preCnt_d    = bus.pre_count;
              wrAddr_d    = '0;
              sampleCnt_d = '0;
              state_d     = (bus.pre_count != '0) ? PREFILL : WAIT_TRIG;
            end
          end
          PREFILL: begin
            wrAddr_d    = wrAddr_q + ADDR_W'(1);
            sampleCnt_d = sampleCnt_q + ADDR_W'(1);
            if (sampleCnt_q + ADDR_W'(1) == preCnt_q) state_d = WAIT_TRIG;
          end
          WAIT_TRIG: begin
            wrAddr_d = wrAddr_q + ADDR_W'(1);
            if (trigHit) begin
              trigAddr_d  = wrAddr_q;
              startAddr_d = wrAddr_q - preCnt_q;
              postCnt_d   = postLoad;
              state_d     = (postLoad != '0) ? POST : DONE;
            end
          end
          POST: begin
            wrAddr_d  = wrAddr_q + ADDR_W'(1);
            postCnt_d = postCnt_q - ADDR_W'(1);
            if (postCnt_q == ADDR_W'(1)) state_d = DONE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wrAddr_q    <= '0;
      trigAddr_q  <= '0;
      startAddr_q <= '0;
      preCnt_q    <= '0;
      sampleCnt_q <= '0;
      postCnt_q   <= '0;
      mask_q      <= '0;
      andMode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrAddr_q    <= wrAddr_d;
      trigAddr_q  <= trigAddr_d;
      startAddr_q <= startAddr_d;
      preCnt_q    <= preCnt_d;
      sampleCnt_q <= sampleCnt_d;
      postCnt_q   <= postCnt_d;
      mask_q      <= mask_d;
      andMode_q   <= andMode_d;
    end
  end

  assign busy           = (state_q == PREFILL) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign bus.busy       = busy;
  assign bus.wr_en      = busy & bus.clk_enable;
  assign bus.wr_addr    = wrAddr_q;
  assign bus.trig_addr  = trigAddr_q;
  assign bus.start_addr = startAddr_q;
  assign bus.waiting    = (state_q == WAIT_TRIG);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// Scoreboard bench for the capture controller: the driver predicts each capture
// from sample-index arithmetic, a monitor checks it when done rises.
module tb_hdlverifier_capture_ctrl;

  localparam int AW    = 4;
  localparam int NT    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hdlverifier_capture_ctrl_if #(.ADDR_W(AW), .NTRIG(NT)) ifc();

  hdlverifier_capture_ctrl #(.ADDR_W(AW), .NTRIG(NT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  typedef struct {
    int trigAddr;
    int startAddr;
    int endAddr;
    int writes;
  } expRec_t;

  expRec_t expQ[$];
  int checks    = 0;
  int failures  = 0;
  int lastTrig  = 0;
  int lastStart = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Trigger rule stated in terms of counts of enabled and asserted inputs.
  function automatic bit modelTrig(input logic [NT-1:0] vec, input logic [NT-1:0] mask, input bit andM);
    int enabled = 0;
    int hits    = 0;
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        enabled++;
        if (vec[i]) hits++;
      end
    end
    if (enabled == 0) return 1'b0;
    return andM ? (hits == enabled) : (hits > 0);
  endfunction

  // Monitor: pops one prediction per rising done and counts RAM writes per capture.
  bit prevBusy  = 1'b0;
  bit prevDone  = 1'b0;
  int writeCount = 0;
  always @(negedge clk) begin
    expRec_t r;
    if (reset) begin
      prevBusy = 1'b0;
      prevDone = 1'b0;
    end else begin
      if (ifc.busy && !prevBusy) writeCount = 0;
      if (ifc.wr_en) writeCount++;
      if (ifc.done && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          r = expQ.pop_front();
          checkOutput("trigAddr", int'(ifc.trig_addr), r.trigAddr);
          checkOutput("startAddr", int'(ifc.start_addr), r.startAddr);
          checkOutput("finalWrAddr", int'(ifc.wr_addr), r.endAddr);
          checkOutput("writeCount", writeCount, r.writes);
          checkOutput("wrEnInDone", int'(ifc.wr_en), 0);
        end
      end
      prevBusy = ifc.busy;
      prevDone = ifc.done;
    end
  end

  task automatic runCapture(input int pre, input logic [NT-1:0] mask, input bit andM,
                            input logic [NT-1:0] baseVec, input logic [NT-1:0] fireVec,
                            input int fireAt, input int f1, input int f2, input int busyArmAt,
                            input bit randomMode, input bit gate, input string tag);
    int k = 0;
    int trigK = -1;
    int cyc = 0;
    bit ce;
    bit tog = 1'b0;
    bit finished = 1'b0;
    bit frc;
    logic [NT-1:0] vec;
    expRec_t r;

    ifc.pre_count  = AW'(pre);
    ifc.trig_mask  = mask;
    ifc.trig_and   = andM;
    ifc.arm        = 1'b1;
    ifc.clk_enable = 1'b1;
    ifc.trig_in    = '0;
    ifc.force_trig = 1'b0;
    applyStimulus();
    ifc.arm = 1'b0;

    while (!finished && cyc < 300) begin
      tog = ~tog;
      if (!gate)           ce = 1'b1;
      else if (randomMode) ce = 1'($urandom_range(0, 1));
      else                 ce = (trigK >= 0) ? tog : 1'b1;
      vec = randomMode ? NT'($urandom) : ((k == fireAt) ? fireVec : baseVec);
      frc = (k == f1) || (k == f2) || (randomMode && k > pre + 40);
      ifc.clk_enable = ce;
      ifc.trig_in    = vec;
      ifc.force_trig = frc;
      ifc.arm        = (k == busyArmAt);
      // Config inputs wander while busy; only the values seen at arm may matter.
      ifc.pre_count  = AW'($urandom);
      ifc.trig_mask  = NT'($urandom);
      ifc.trig_and   = 1'($urandom);
      if (ce && trigK < 0 && k >= pre && (frc || modelTrig(vec, mask, andM))) begin
        trigK       = k;
        r.trigAddr  = k % DEPTH;
        r.startAddr = (k - pre) % DEPTH;
        r.writes    = k + DEPTH - pre;
        r.endAddr   = r.writes % DEPTH;
        expQ.push_back(r);
        lastTrig  = r.trigAddr;
        lastStart = r.startAddr;
      end
      applyStimulus();
      if (ce) k++;
      cyc++;
      if (ifc.done) finished = 1'b1;
    end

    ifc.arm        = 1'b0;
    ifc.force_trig = 1'b0;
    ifc.clk_enable = 1'b1;
    if (!finished) begin
      checkOutput({tag, "Timeout"}, 0, 1);
      if (trigK >= 0 && expQ.size() > 0) void'(expQ.pop_back());
    end
  endtask

  task automatic runInterrupted(input int pre, input int fireAt, input int intrAt,
                                input bit useReset, input bit armToo, input string tag);
    ifc.pre_count  = AW'(pre);
    ifc.trig_mask  = 4'b0001;
    ifc.trig_and   = 1'b0;
    ifc.arm        = 1'b1;
    ifc.clk_enable = 1'b1;
    ifc.trig_in    = '0;
    ifc.force_trig = 1'b0;
    applyStimulus();
    ifc.arm = 1'b0;

    for (int k = 0; k <= intrAt; k++) begin
      ifc.trig_in = (k == fireAt) ? 4'b0001 : 4'b0000;
      if (k == intrAt) begin
        if (useReset) reset = 1'b1;
        else begin
          ifc.abort = 1'b1;
          ifc.arm   = armToo;
        end
      end else if (k == fireAt && k >= pre) begin
        lastTrig  = k % DEPTH;
        lastStart = (k - pre) % DEPTH;
      end
      applyStimulus();
    end
    reset       = 1'b0;
    ifc.abort   = 1'b0;
    ifc.arm     = 1'b0;
    ifc.trig_in = '0;
    if (useReset) begin
      lastTrig  = 0;
      lastStart = 0;
      checkOutput({tag, "WrAddr"}, int'(ifc.wr_addr), 0);
    end
    checkOutput({tag, "Busy"}, int'(ifc.busy), 0);
    checkOutput({tag, "Waiting"}, int'(ifc.waiting), 0);
    checkOutput({tag, "Done"}, int'(ifc.done), 0);
    checkOutput({tag, "WrEn"}, int'(ifc.wr_en), 0);
    checkOutput({tag, "TrigAddr"}, int'(ifc.trig_addr), lastTrig);
    checkOutput({tag, "StartAddr"}, int'(ifc.start_addr), lastStart);
    applyStimulus();
    checkOutput({tag, "StaysIdle"}, int'(ifc.busy), 0);
  endtask

  task automatic abortArmFromDone();
    ifc.abort      = 1'b1;
    ifc.arm        = 1'b1;
    ifc.pre_count  = AW'(3);
    ifc.clk_enable = 1'b1;
    applyStimulus();
    ifc.abort = 1'b0;
    ifc.arm   = 1'b0;
    checkOutput("abortArmBusy", int'(ifc.busy), 0);
    checkOutput("abortArmDone", int'(ifc.done), 0);
    checkOutput("abortArmTrigAddr", int'(ifc.trig_addr), lastTrig);
    checkOutput("abortArmStartAddr", int'(ifc.start_addr), lastStart);
    applyStimulus();
    checkOutput("abortArmStaysIdle", int'(ifc.busy), 0);
  endtask

  initial begin
    int pre;
    logic [NT-1:0] mask;

    reset          = 1'b1;
    ifc.clk_enable = 1'b1;
    ifc.arm        = 1'b0;
    ifc.abort      = 1'b0;
    ifc.force_trig = 1'b0;
    ifc.trig_in    = '0;
    ifc.trig_mask  = '0;
    ifc.trig_and   = 1'b0;
    ifc.pre_count  = '0;
    repeat (2) applyStimulus();
    checkOutput("rstWrEn", int'(ifc.wr_en), 0);
    checkOutput("rstWrAddr", int'(ifc.wr_addr), 0);
    checkOutput("rstTrigAddr", int'(ifc.trig_addr), 0);
    checkOutput("rstStartAddr", int'(ifc.start_addr), 0);
    checkOutput("rstBusy", int'(ifc.busy), 0);
    checkOutput("rstWaiting", int'(ifc.waiting), 0);
    checkOutput("rstDone", int'(ifc.done), 0);
    reset = 1'b0;
    applyStimulus();

    runCapture(5, 4'b0001, 1'b0, 4'b0000, 4'b0001, 8, -1, -1, -1, 1'b0, 1'b0, "basicOr");
    runInterrupted(2, 5, 5, 1'b0, 1'b0, "abortTrig");
    runCapture(4, 4'b0011, 1'b1, 4'b0001, 4'b0011, 30, -1, -1, 10, 1'b0, 1'b0, "wrapAnd");
    abortArmFromDone();
    runCapture(6, 4'b0001, 1'b0, 4'b0001, 4'b0001, -1, -1, -1, -1, 1'b0, 1'b0, "prefillImmune");
    runCapture(0, 4'b0001, 1'b0, 4'b0001, 4'b0001, -1, -1, -1, -1, 1'b0, 1'b0, "preZero");
    runCapture(15, 4'b0001, 1'b0, 4'b0001, 4'b0001, -1, -1, -1, -1, 1'b0, 1'b0, "preMax");
    runCapture(6, 4'b0000, 1'b0, 4'b1111, 4'b1111, -1, 3, 10, -1, 1'b0, 1'b0, "maskZero");
    runCapture(5, 4'b0001, 1'b0, 4'b0000, 4'b0001, 8, -1, -1, -1, 1'b0, 1'b1, "gatedPost");
    runInterrupted(3, -1, 6, 1'b0, 1'b1, "abortArmWait");
    runInterrupted(5, 7, 10, 1'b1, 1'b0, "resetPost");

    for (int n = 0; n < 12; n++) begin
      pre  = $urandom_range(0, DEPTH - 1);
      mask = NT'($urandom_range(1, 15));
      runCapture(pre, mask, 1'($urandom), 4'b0000, 4'b0000, -1, -1, -1,
                 $urandom_range(0, pre), 1'b1, 1'($urandom), "random");
    end

    repeat (3) applyStimulus();
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
